// File: rtl/sm_pkg.sv
// sm_pkg: definitions shared by the target packer and its base encoder.
//   - default field sizes for the packed {ID, LENGTH, TARGET} word
//   - the ASCII base characters and their 2-bit codes
//   - the packer FSM state type
package sm_pkg;

   localparam int TARGET_LENGTH_DEF = 128;
   localparam int LEN_WIDTH_DEF     = 12;
   localparam int ID_WIDTH_DEF      = 48;

   localparam logic [7:0] ASCII_A_UP = 8'h41;
   localparam logic [7:0] ASCII_C_UP = 8'h43;
   localparam logic [7:0] ASCII_G_UP = 8'h47;
   localparam logic [7:0] ASCII_T_UP = 8'h54;
   localparam logic [7:0] ASCII_A_LO = 8'h61;
   localparam logic [7:0] ASCII_C_LO = 8'h63;
   localparam logic [7:0] ASCII_G_LO = 8'h67;
   localparam logic [7:0] ASCII_T_LO = 8'h74;

   localparam logic [1:0] CODE_A = 2'b00;
   localparam logic [1:0] CODE_C = 2'b01;
   localparam logic [1:0] CODE_G = 2'b10;
   localparam logic [1:0] CODE_T = 2'b11;

   typedef enum logic [1:0] {
      S_ID    = 2'd0,
      S_BASES = 2'd1,
      S_ISSUE = 2'd2,
      S_GAP   = 2'd3
   } state_t;

endpackage

// File: rtl/sm_base_encode.sv
// sm_base_encode: combinational ASCII base -> 2-bit code.
//   data : input byte (upper or lower case A/C/G/T)
//   code : 2-bit base code; any unrecognised byte encodes as A (00)
module sm_base_encode
   import sm_pkg::*;
(
   input  logic [7:0] data,
   output logic [1:0] code
);

   always_comb begin
      code = CODE_A;
      case (data)
         ASCII_A_UP, ASCII_A_LO: code = CODE_A;
         ASCII_C_UP, ASCII_C_LO: code = CODE_C;
         ASCII_G_UP, ASCII_G_LO: code = CODE_G;
         ASCII_T_UP, ASCII_T_LO: code = CODE_T;
         default:                code = CODE_A;
      endcase
   end

endmodule

// File: rtl/sm_target_packer.sv
// sm_target_packer: packs a byte stream of sequence records (ID bytes, then
// ASCII bases) into one {ID, LENGTH, TARGET} word per record and loads it
// into the scoring-bank feeder.
//
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   s_data/s_valid/
//   s_last/s_ready    byte stream; a byte moves when s_valid && s_ready,
//                     s_last marks the final byte of a record
//   full              feeder full flag (combinational from the feeder)
//   ld                one-cycle load strobe, only while full==0
//   feed_out          packed word {ID, LENGTH, BASES}, first base in [1:0]
//   ovf               pulses with ld when the record was truncated
//   err               pulses the cycle after a record ended inside its ID
module sm_target_packer
   import sm_pkg::*;
#(
   parameter int TARGET_LENGTH = TARGET_LENGTH_DEF,
   parameter int LEN_WIDTH     = LEN_WIDTH_DEF,
   parameter int ID_WIDTH      = ID_WIDTH_DEF,
   parameter int IN_WIDTH      = ID_WIDTH + LEN_WIDTH + 2*TARGET_LENGTH
)
(
   input  logic                clk,
   input  logic                rst,
   input  logic [7:0]          s_data,
   input  logic                s_valid,
   input  logic                s_last,
   output logic                s_ready,
   input  logic                full,
   output logic                ld,
   output logic [IN_WIDTH-1:0] feed_out,
   output logic                ovf,
   output logic                err
);

   localparam int IDX_W = $clog2(TARGET_LENGTH);
   localparam logic [7:0]           ID_LAST = 8'(ID_WIDTH/8 - 1);
   localparam logic [LEN_WIDTH-1:0] TL_L    = LEN_WIDTH'(TARGET_LENGTH);

   state_t                     state;
   logic [7:0]                 id_cnt;
   logic [LEN_WIDTH-1:0]       base_cnt;
   logic                       ovf_flag;
   logic                       gap_cnt;
   logic [ID_WIDTH-1:0]        id_q;
   logic [LEN_WIDTH-1:0]       len_q;
   logic [2*TARGET_LENGTH-1:0] bases_q;

   logic                accept;
   logic [1:0]          code;
   logic [ID_WIDTH+7:0] id_shift;
   logic [IDX_W-1:0]    base_idx;
   logic                has_room;

   sm_base_encode u_enc (
      .data (s_data),
      .code (code)
   );

   assign accept   = s_valid && s_ready;
   assign id_shift = {id_q, s_data};
   assign base_idx = base_cnt[IDX_W-1:0];
   assign has_room = (base_cnt < TL_L);

   // ld is combinational so it can never overlap a cycle in which the
   // feeder reports full; s_ready is already low throughout S_ISSUE.
   assign ld       = (state == S_ISSUE) && !full;
   assign ovf      = ld && ovf_flag;
   assign feed_out = {id_q, len_q, bases_q};

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= S_ID;
         id_cnt   <= '0;
         base_cnt <= '0;
         ovf_flag <= 1'b0;
         gap_cnt  <= 1'b0;
         s_ready  <= 1'b0;
         err      <= 1'b0;
         id_q     <= '0;
         len_q    <= '0;
         bases_q  <= '0;
      end else begin
         err <= 1'b0;
         case (state)
            S_ID: begin
               s_ready <= 1'b1;
               if (accept) begin
                  // First byte of a new record: the previous word stays on
                  // feed_out until now, then the bases field starts clean.
                  if (id_cnt == '0) begin
                     bases_q <= '0;
                  end
                  id_q <= id_shift[ID_WIDTH-1:0];
                  if (s_last) begin
                     err    <= 1'b1;
                     id_cnt <= '0;
                  end else if (id_cnt == ID_LAST) begin
                     id_cnt   <= '0;
                     base_cnt <= '0;
                     ovf_flag <= 1'b0;
                     state    <= S_BASES;
                  end else begin
                     id_cnt <= id_cnt + 8'd1;
                  end
               end
            end

            S_BASES: begin
               if (accept) begin
                  if (has_room) begin
                     bases_q[{base_idx, 1'b0} +: 2] <= code;
                     base_cnt <= base_cnt + LEN_WIDTH'(1);
                  end else begin
                     ovf_flag <= 1'b1;
                  end
                  if (s_last) begin
                     len_q   <= has_room ? (base_cnt + LEN_WIDTH'(1)) : TL_L;
                     s_ready <= 1'b0;
                     state   <= S_ISSUE;
                  end
               end
            end

            S_ISSUE: begin
               s_ready <= 1'b0;
               if (!full) begin
                  gap_cnt <= 1'b0;
                  state   <= S_GAP;
               end
            end

            S_GAP: begin
               // Two idle cycles so the feeder's registered load and full
               // flag settle before the next record can complete.
               if (gap_cnt) begin
                  id_cnt  <= '0;
                  s_ready <= 1'b1;
                  state   <= S_ID;
               end else begin
                  gap_cnt <= 1'b1;
               end
            end

            default: begin
               s_ready <= 1'b0;
               state   <= S_ID;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sm_target_packer.sv
// tb_sm_target_packer: scoreboard bench for sm_target_packer.
// Handshake: a byte moves on a rising edge where s_valid && s_ready; the
// packed word is consumed on the cycle ld is high.
module tb_sm_target_packer;

   localparam int TL = 128;
   localparam int LW = 12;
   localparam int IW = 48;
   localparam int W  = IW + LW + 2*TL;

   logic         clk;
   logic         rst;
   logic [7:0]   s_data;
   logic         s_valid;
   logic         s_last;
   logic         s_ready;
   logic         full;
   logic         ld;
   logic [W-1:0] feed_out;
   logic         ovf;
   logic         err;

   // expected entry: {ovf, packed word}
   logic [W:0]   exp_q[$];
   logic [7:0]   bq[$];
   int           n_tests = 0;
   int           n_fail  = 0;
   int           ld_count = 0;
   int           err_count = 0;
   int           acc_count = 0;

   sm_target_packer #(
      .TARGET_LENGTH (TL),
      .LEN_WIDTH     (LW),
      .ID_WIDTH      (IW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .s_data   (s_data),
      .s_valid  (s_valid),
      .s_last   (s_last),
      .s_ready  (s_ready),
      .full     (full),
      .ld       (ld),
      .feed_out (feed_out),
      .ovf      (ovf),
      .err      (err)
   );

   // ---------------- clock / watchdog ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- checker ----------------
   task automatic check_eq(input string tag, input logic [W:0] got, input logic [W:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [1:0] enc(input logic [7:0] c);
      case (c)
         8'h41, 8'h61: enc = 2'b00;
         8'h43, 8'h63: enc = 2'b01;
         8'h47, 8'h67: enc = 2'b10;
         8'h54, 8'h74: enc = 2'b11;
         default:      enc = 2'b00;
      endcase
   endfunction

   function automatic logic [W:0] build_exp(input logic [IW-1:0] id);
      logic [2*TL-1:0] b;
      logic [LW-1:0]   len;
      int              n;
      b = '0;
      n = bq.size();
      for (int i = 0; i < n && i < TL; i++) b[2*i +: 2] = enc(bq[i]);
      len = (n > TL) ? LW'(TL) : LW'(n);
      return {(n > TL), id, len, b};
   endfunction

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (rst) begin
         if (ld) begin
            ld_count++;
            check_eq("ld_vs_full", {{W{1'b0}}, full}, '0);
            check_eq("ld_vs_ready", {{W{1'b0}}, s_ready}, '0);
            if (exp_q.size() == 0) begin
               check_eq("ld_unexpected", 1, 0);
            end else begin
               check_eq("packed_word", {ovf, feed_out}, exp_q.pop_front());
            end
         end else if (ovf) begin
            check_eq("ovf_stray", {{W{1'b0}}, ovf}, '0);
         end
         if (err) err_count++;
      end
   end

   // ---------------- driver tasks (called at a negedge) ----------------
   task automatic send_byte(input logic [7:0] d, input logic l);
      int waited;
      s_data  = d;
      s_valid = 1'b1;
      s_last  = l;
      waited  = 0;
      while (!s_ready && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (!s_ready) check_eq("send_timeout", 1, 0);
      else acc_count++;
      @(posedge clk);
      @(negedge clk);
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic send_id(input logic [IW-1:0] id);
      for (int k = 0; k < IW/8; k++) send_byte(id[IW-1-8*k -: 8], 1'b0);
   endtask

   task automatic load_str(input string s);
      bq.delete();
      for (int i = 0; i < s.len(); i++) bq.push_back(s[i]);
   endtask

   // full record: expected entry is queued just before the last byte
   task automatic send_record(input logic [IW-1:0] id);
      send_id(id);
      for (int j = 0; j < bq.size(); j++) begin
         if (j == bq.size() - 1) exp_q.push_back(build_exp(id));
         send_byte(bq[j], (j == bq.size() - 1));
      end
   endtask

   task automatic wait_idle();
      int waited;
      waited = 0;
      while (!s_ready && waited < 60) begin
         @(negedge clk);
         waited++;
      end
      if (!s_ready) check_eq("idle_timeout", 1, 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst     = 1'b0;
      s_data  = 8'h00;
      s_valid = 1'b0;
      s_last  = 1'b0;
      full    = 1'b0;
      repeat (3) @(negedge clk);

      check_eq("rst_s_ready", {{W{1'b0}}, s_ready}, '0);
      check_eq("rst_ld", {{W{1'b0}}, ld}, '0);
      check_eq("rst_ovf_err", {{(W-1){1'b0}}, ovf, err}, '0);
      check_eq("rst_feed_out", {1'b0, feed_out}, '0);
      rst = 1'b1;
      @(negedge clk);

      // 1: basic record
      load_str("ACGT");
      send_record(48'h0123456789AB);
      wait_idle();
      check_eq("t1_bases", {{(W-7){1'b0}}, feed_out[7:0]}, 8'he4);
      check_eq("t1_len", {{(W-LW+1){1'b0}}, feed_out[2*TL +: LW]}, 4);
      check_eq("t1_id", {{(W-IW+1){1'b0}}, feed_out[W-1 -: IW]}, 48'h0123456789AB);
      check_eq("t1_ld_count", ld_count, 1);

      // 2: feeder full holds the word back
      full = 1'b1;
      send_record(48'h0123456789AB);
      for (int c = 0; c < 10; c++) begin
         check_eq("t2_hold_ready", {{W{1'b0}}, s_ready}, '0);
         check_eq("t2_hold_ld", {{W{1'b0}}, ld}, '0);
         @(negedge clk);
      end
      @(posedge clk);
      #1 full = 1'b0;
      @(negedge clk);
      check_eq("t2_ld_on_release", {{W{1'b0}}, ld}, 1);
      wait_idle();
      check_eq("t2_ld_count", ld_count, 2);

      // 3: overflow, 130 bases into a 128-base target
      bq.delete();
      for (int i = 0; i < 130; i++) bq.push_back(8'h47);
      acc_count = 0;
      send_record(48'hA5A5_0000_FFFF);
      wait_idle();
      check_eq("t3_accepted", acc_count, 136);
      check_eq("t3_bases", {1'b0, feed_out[2*TL-1:0]}, {128{2'b10}});
      check_eq("t3_len", {{(W-LW+1){1'b0}}, feed_out[2*TL +: LW]}, 128);

      // 4: record ending inside its ID, then a one-base record
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      send_byte(8'h33, 1'b1);
      check_eq("t4_err_pulse", {{W{1'b0}}, err}, 1);
      @(negedge clk);
      check_eq("t4_err_single", {{W{1'b0}}, err}, 0);
      check_eq("t4_no_ld", ld_count, 3);
      load_str("T");
      send_record(48'h1122_3344_5566);
      wait_idle();
      check_eq("t4_len1", {{(W-LW+1){1'b0}}, feed_out[2*TL +: LW]}, 1);
      check_eq("t4_bases", {1'b0, feed_out[2*TL-1:0]}, 2'b11);

      // 5: lowercase and an unknown character
      load_str("acgn");
      send_record(48'hDEAD_BEEF_0042);
      wait_idle();
      check_eq("t5_bases", {{(W-7){1'b0}}, feed_out[7:0]}, 8'b00_10_01_00);

      // 6: reset in the middle of a record's bases
      send_id(48'hCAFE_F00D_1234);
      load_str("ACGT");
      for (int j = 0; j < 4; j++) send_byte(bq[j], 1'b0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("t6_rst_feed_out", {1'b0, feed_out}, '0);
      check_eq("t6_rst_ready", {{W{1'b0}}, s_ready}, '0);
      rst = 1'b1;
      @(negedge clk);
      load_str("C");
      send_record(48'h0000_0000_0007);
      wait_idle();
      check_eq("t6_bases", {1'b0, feed_out[2*TL-1:0]}, 2'b01);
      check_eq("t6_len", {{(W-LW+1){1'b0}}, feed_out[2*TL +: LW]}, 1);

      repeat (5) @(negedge clk);
      check_eq("final_ld_count", ld_count, 6);
      check_eq("final_err_count", err_count, 1);
      check_eq("final_queue_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
